// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg
// Shared types and helpers for the RGB LED sequencer and its receive-side
// checker.
//   colour_e    : decoded LED colour, same encoding the sequencer drives.
//   err_e       : checker error cause codes (NONE plus four causes).
//   decoded_t   : colour plus a flag for patterns with two or more LEDs lit.
//   decode_rgb  : maps {red,green,blue} to decoded_t.
//   next_colour : legal successor of a colour in BLANK->RED->GREEN->BLUE.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b11,
    BLUE  = 2'b10
  } colour_e;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    MULTI_HOT = 3'd1,
    ORDER     = 3'd2,
    SHORT     = 3'd3,
    LONG      = 3'd4
  } err_e;

  typedef struct packed {
    colour_e colour;
    logic    multi;
  } decoded_t;

  // A multi-hot pattern has no meaningful colour, so it reports BLANK with
  // the multi flag set; callers must look at the flag before the colour.
  function automatic decoded_t decode_rgb(input logic [2:0] rgb);
    decoded_t d;
    d.colour = BLANK;
    d.multi  = 1'b0;
    case (rgb)
      3'b000:  d.colour = BLANK;
      3'b100:  d.colour = RED;
      3'b010:  d.colour = GREEN;
      3'b001:  d.colour = BLUE;
      default: d.multi  = 1'b1;
    endcase
    return d;
  endfunction

  // The sequence wraps: BLUE is followed by BLANK.
  function automatic colour_e next_colour(input colour_e c);
    colour_e n;
    case (c)
      BLANK:   n = RED;
      RED:     n = GREEN;
      GREEN:   n = BLUE;
      default: n = BLANK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rgb_seq_checker_if.sv
// rgb_seq_checker_if
// Bundles the sequencer LED lines and the checker's report outputs.
//   red/green/blue : LED lines driven by the sequencer (master) side.
//   phase          : decoded colour, registered.
//   seq_done       : one-cycle pulse per correct full sequence.
//   err            : one-cycle pulse per detected error.
//   err_code       : cause of the latest error.
//   seq_count      : saturating count of good sequences, COUNT_WIDTH bits.
// Modports: master drives the LEDs and observes reports; slave is the checker.
interface rgb_seq_checker_if #(
  parameter int COUNT_WIDTH = 16
);
  import rgb_seq_pkg::*;

  logic                   red;
  logic                   green;
  logic                   blue;
  colour_e                phase;
  logic                   seq_done;
  logic                   err;
  err_e                   err_code;
  logic [COUNT_WIDTH-1:0] seq_count;

  modport master (
    output red, green, blue,
    input  phase, seq_done, err, err_code, seq_count
  );

  modport slave (
    input  red, green, blue,
    output phase, seq_done, err, err_code, seq_count
  );

endinterface

// File: rtl/rgb_seq_checker_phase_timer.sv
// rgb_phase_timer
// Run-length counter: restarts at 1 whenever the observed value changes and
// otherwise counts up, saturating at MAX_COUNT.
//   clk     : rising-edge clock.
//   reset_n : synchronous active-low reset, clears the count to 0.
//   restart : high when the current sample differs from the previous one.
//   count   : length of the current run, including the latest sample.
module rgb_phase_timer #(
  parameter int MAX_COUNT = 11,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  output logic [WIDTH-1:0] count
);

  // Saturation keeps a stuck colour from wrapping back into the legal range.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart) begin
      count <= WIDTH'(1);
    end else if (count != WIDTH'(MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_seq_checker.sv
// rgb_seq_checker
// Watches the RGB sequencer outputs and checks the BLANK->RED->GREEN->BLUE->
// BLANK order and the length of each colour phase.
//   clk     : rising-edge clock.
//   reset_n : synchronous active-low reset.
//   bus     : rgb_seq_checker_if slave (LED inputs, phase/seq_done/err/
//             err_code/seq_count outputs, all outputs registered).
// Latency: an LED change before edge t shows on the outputs after edge t+1.
// Parameters: PHASE_LEN (colour high-time in cycles, at least 2),
//             COUNT_WIDTH (must match the interface instance).
// Optional macro RGB_SEQ_CHECKER_TOLERANCE_EN accepts phase lengths of
// PHASE_LEN-1..PHASE_LEN+1 instead of exactly PHASE_LEN.
module rgb_seq_checker
  import rgb_seq_pkg::*;
#(
  parameter int PHASE_LEN   = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  rgb_seq_checker_if.slave bus
);

`ifdef RGB_SEQ_CHECKER_TOLERANCE_EN
  localparam int MIN_LEN = PHASE_LEN - 1;
  localparam int MAX_LEN = PHASE_LEN + 1;
`else
  localparam int MIN_LEN = PHASE_LEN;
  localparam int MAX_LEN = PHASE_LEN;
`endif
  localparam int TIMER_MAX = MAX_LEN + 1;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {RESYNC, IDLE, S_RED, S_GREEN, S_BLUE} state_e;

  state_e                 state;
  logic [2:0]             rgb_q;
  logic [2:0]             rgb_last;
  logic [TIMER_W-1:0]     timer;
  decoded_t               cur;
  colour_e                state_colour;
  err_e                   check_err;
  colour_e                phase_q;
  logic                   seq_done_q;
  logic                   err_q;
  err_e                   err_code_q;
  logic [COUNT_WIDTH-1:0] seq_count_q;

  // Input pipeline. Not reset on purpose: after a reset the checker must see
  // the real LED state, so resetting to BLANK could fake a resync point
  // in the middle of a colour.
  always_ff @(posedge clk) begin
    rgb_q    <= {bus.red, bus.green, bus.blue};
    rgb_last <= rgb_q;
  end

  // The FSM samples timer before it updates, so at each decision timer holds
  // the length of the run that ended with rgb_last.
  rgb_phase_timer #(
    .MAX_COUNT (TIMER_MAX),
    .WIDTH     (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (rgb_q != rgb_last),
    .count   (timer)
  );

  // Error detection for the current sample. Nesting gives the priority
  // MULTI_HOT > LONG > SHORT > ORDER; LONG only arises while the colour
  // holds, SHORT and ORDER only once it has changed. RESYNC never errors.
  always_comb begin
    cur = decode_rgb(rgb_q);
    case (state)
      S_RED:   state_colour = RED;
      S_GREEN: state_colour = GREEN;
      S_BLUE:  state_colour = BLUE;
      default: state_colour = BLANK;
    endcase
    check_err = NONE;
    if (state != RESYNC) begin
      if (cur.multi) begin
        check_err = MULTI_HOT;
      end else if (state == IDLE) begin
        if (cur.colour != BLANK && cur.colour != RED) begin
          check_err = ORDER;
        end
      end else if (cur.colour == state_colour) begin
        if (timer >= TIMER_W'(MAX_LEN)) begin
          check_err = LONG;
        end
      end else if (timer < TIMER_W'(MIN_LEN)) begin
        check_err = SHORT;
      end else if (cur.colour != next_colour(state_colour)) begin
        check_err = ORDER;
      end
    end
  end

  // Sequence FSM and registered outputs. Any error drops back to RESYNC,
  // which waits for a clean BLANK before trusting the LEDs again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RESYNC;
      phase_q     <= BLANK;
      seq_done_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= NONE;
      seq_count_q <= '0;
    end else begin
      phase_q    <= cur.colour;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      if (check_err != NONE) begin
        err_q      <= 1'b1;
        err_code_q <= check_err;
        state      <= RESYNC;
      end else begin
        case (state)
          RESYNC:  if (!cur.multi && cur.colour == BLANK) state <= IDLE;
          IDLE:    if (cur.colour == RED) state <= S_RED;
          S_RED:   if (cur.colour == GREEN) state <= S_GREEN;
          S_GREEN: if (cur.colour == BLUE) state <= S_BLUE;
          S_BLUE: begin
            if (cur.colour == BLANK) begin
              state      <= IDLE;
              seq_done_q <= 1'b1;
              if (seq_count_q != '1) begin
                seq_count_q <= seq_count_q + 1'b1;
              end
            end
          end
          default: state <= RESYNC;
        endcase
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.seq_count = seq_count_q;

endmodule
